// File: rtl/pkt_stream_tx.sv
// Store-and-forward packet source for a 32-bit Avalon-ST stream.
// Host writes packet words into a circular buffer; only complete packets are replayed, honouring ready.
module pkt_stream_tx #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  input  logic             wr_last,
  input  logic [1:0]       wr_empty,
  output logic             full,
  output logic             overflow,
  output logic [31:0]      data,
  output logic             valid,
  input  logic             ready,
  output logic             sop,
  output logic             eop,
  output logic [1:0]       empty,
  output logic [5:0]       error,
  output logic [CNT_W-1:0] tx_pkts
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  empty;
  } entry_t;

  entry_t mem [DEPTH];

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d, pkt_cnt_q, pkt_cnt_d, pkt_after;
  logic            last_pend_q, last_pend_d;
  logic            overflow_q, overflow_d;
  logic            valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [1:0]      empty_q, empty_d;
  logic [31:0]     data_q, data_d;
  logic [CNT_W-1:0] tx_pkts_q, tx_pkts_d;
  logic            pop, wr_acc, xfer, is_full;
  entry_t          head;

  // A completed packet is counted one cycle after its last word lands, so
  // whatever the FSM pops is always already sitting in the buffer.
  always_comb begin
    head      = mem[rd_ptr_q];
    xfer      = valid_q & ready;
    is_full   = (count_q == FULL_CNT);
    pkt_after = pkt_cnt_q + (AW+1)'(last_pend_q) - (AW+1)'(xfer & eop_q);

    state_d   = state_q;
    valid_d   = valid_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    empty_d   = empty_q;
    data_d    = data_q;
    tx_pkts_d = tx_pkts_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pkt_cnt_q != '0) begin
          pop     = 1'b1;
          sop_d   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!eop_q) begin
            pop   = 1'b1;
            sop_d = 1'b0;
          end else begin
            tx_pkts_d = tx_pkts_q + CNT_W'(1);
            if (pkt_after != '0) begin
              pop   = 1'b1;
              sop_d = 1'b1;
            end else begin
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
              empty_d = 2'd0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      valid_d = 1'b1;
      data_d  = head.data;
      eop_d   = head.last;
      empty_d = head.last ? head.empty : 2'd0;
    end

    wr_acc      = wr_en & (~is_full | pop);
    overflow_d  = wr_en & is_full & ~pop;
    last_pend_d = wr_acc & wr_last;
    pkt_cnt_d   = pkt_after;
    count_d     = count_q + (AW+1)'(wr_acc) - (AW+1)'(pop);
    wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= '{data: wr_data, last: wr_last, empty: wr_empty};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_cnt_q   <= '0;
      last_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      empty_q     <= 2'd0;
      data_q      <= '0;
      tx_pkts_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_cnt_q   <= pkt_cnt_d;
      last_pend_q <= last_pend_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      empty_q     <= empty_d;
      data_q      <= data_d;
      tx_pkts_q   <= tx_pkts_d;
    end
  end

  assign full     = is_full;
  assign overflow = overflow_q;
  assign data     = data_q;
  assign valid    = valid_q;
  assign sop      = sop_q;
  assign eop      = eop_q;
  assign empty    = empty_q;
  assign error    = 6'd0;
  assign tx_pkts  = tx_pkts_q;

endmodule

// File: tb/tb_pkt_stream_tx.sv
// Scoreboarded bench for pkt_stream_tx: writes push expected stream words,
// an independent monitor pops and compares on every accepted transfer.
module tb_pkt_stream_tx;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_last = 1'b0;
  logic [1:0]  wr_empty = 2'd0;
  logic        ready = 1'b0;
  logic        full, overflow, valid, sop, eop;
  logic [31:0] data;
  logic [1:0]  empty;
  logic [5:0]  error;
  logic [31:0] tx_pkts;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_tx = 0;
  bit   rand_ready = 1'b0;

  pkt_stream_tx #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_empty(wr_empty), .full(full), .overflow(overflow), .data(data), .valid(valid),
    .ready(ready), .sop(sop), .eop(eop), .empty(empty), .error(error), .tx_pkts(tx_pkts)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("[TB] FAIL %s: timed out, expected event never seen", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  // Waits for buffer room so the write is certain to be accepted, then records the expected word.
  task automatic apply_word(input logic [31:0] d, input logic last, input logic [1:0] e, input logic first);
    int guard = 0;
    while (full === 1'b1 && guard < 500) begin
      tick();
      guard++;
    end
    if (guard >= 500) timeout_fail("write_wait");
    wr_en    = 1'b1;
    wr_data  = d;
    wr_last  = last;
    wr_empty = e;
    exp_q.push_back('{d: d, sop: first, eop: last, emp: (last ? e : 2'd0)});
    tick();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic apply_packet(input int len);
    for (int i = 0; i < len; i++)
      apply_word($urandom, (i == len - 1), 2'($urandom_range(0, 3)), (i == 0));
  endtask

  task automatic wait_valid(input string name);
    int guard = 0;
    while (valid !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) timeout_fail(name);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || valid === 1'b1) && guard < 4000) begin
      tick();
      guard++;
    end
    if (guard >= 4000) timeout_fail(name);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    wr_en = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  // Monitor: compares every accepted word against the queue and checks stall stability.
  initial begin
    exp_t        e;
    logic        stalled;
    logic [31:0] hd;
    logic        hs, he;
    logic [1:0]  hm;
    stalled = 1'b0;
    hd = '0; hs = 1'b0; he = 1'b0; hm = 2'd0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        exp_q.delete();
        exp_tx  = 0;
        stalled = 1'b0;
      end
      check_output("tx_pkts", tx_pkts, exp_tx);
      if (stalled) begin
        check_output("hold_valid", valid, 1);
        check_output("hold_data", data, hd);
        check_output("hold_sop", sop, hs);
        check_output("hold_eop", eop, he);
        check_output("hold_empty", empty, hm);
      end
      if (valid === 1'b1 && ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_word");
        end else begin
          e = exp_q.pop_front();
          check_output("word_data", data, e.d);
          check_output("word_sop", sop, e.sop);
          check_output("word_eop", eop, e.eop);
          check_output("word_empty", empty, e.emp);
          check_output("word_error", error, 0);
          if (e.eop) exp_tx++;
        end
      end
      stalled = (valid === 1'b1) && (ready !== 1'b1);
      hd = data; hs = sop; he = eop; hm = empty;
    end
  end

  initial begin
    tick();
    check_output("rst_valid", valid, 0);
    check_output("rst_sop", sop, 0);
    check_output("rst_eop", eop, 0);
    check_output("rst_full", full, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_data", data, 0);
    check_output("rst_empty", empty, 0);
    check_output("rst_error", error, 0);
    check_output("rst_tx_pkts", tx_pkts, 0);
    n_rst = 1'b1;
    tick();

    // Single-word packet: valid appears two edges after the accepting edge.
    ready = 1'b1;
    apply_word(32'hDEADBEEF, 1'b1, 2'd2, 1'b1);
    check_output("lat_edge_n", valid, 0);
    tick();
    check_output("lat_edge_n1", valid, 0);
    tick();
    check_output("lat_edge_n2_valid", valid, 1);
    check_output("lat_sop", sop, 1);
    check_output("lat_eop", eop, 1);
    check_output("lat_empty", empty, 2);
    check_output("lat_data", data, 32'hDEADBEEF);
    drain("drain_single");
    check_output("single_tx_pkts", tx_pkts, 1);

    // Four-word packet with a three-cycle stall after the first transfer.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) apply_word(32'h1000 + i, (i == 3), 2'd1, (i == 0));
    wait_valid("stall_valid");
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick(); tick(); tick();
    ready = 1'b1;
    drain("drain_stall");

    // Two 3-word packets buffered, then streamed back to back.
    ready = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 3; i++) apply_word(32'h2000 + 16 * p + i, (i == 2), 2'd3, (i == 0));
    tick(); tick(); tick();
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("b2b_valid", valid, 1);
    end
    @(negedge clk);
    check_output("b2b_idle_after", valid, 0);
    drain("drain_b2b");
    check_output("b2b_tx_pkts", tx_pkts, 4);

    // Oversized packet: fills the buffer, 17th write overflows, nothing is sent.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h3000 + i;
      wr_last = 1'b0;
      tick();
      if (i == 14) check_output("ovf_full_15", full, 0);
      if (i == 15) begin
        check_output("ovf_full_16", full, 1);
        check_output("ovf_no_pulse_16", overflow, 0);
      end
      if (i == 16) check_output("ovf_pulse_17", overflow, 1);
    end
    wr_en = 1'b0;
    tick();
    check_output("ovf_pulse_end", overflow, 0);
    check_output("ovf_still_full", full, 1);
    check_output("ovf_no_valid", valid, 0);

    // Full buffer with pop and write in the same cycle.
    do_reset();
    for (int i = 0; i < DEPTH; i++) apply_word(32'h4000 + i, (i == DEPTH - 1), 2'd1, (i == 0));
    wait_valid("full_pop_valid");
    apply_word(32'h5000, 1'b0, 2'd0, 1'b1);
    check_output("full_before_pop", full, 1);
    ready    = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 32'h5001;
    wr_last  = 1'b0;
    exp_q.push_back('{d: 32'h5001, sop: 1'b0, eop: 1'b0, emp: 2'd0});
    tick();
    wr_en = 1'b0;
    ready = 1'b0;
    check_output("pop_write_full", full, 1);
    check_output("pop_write_no_ovf", overflow, 0);
    tick();
    check_output("pop_write_no_ovf_late", overflow, 0);
    ready = 1'b1;
    apply_word(32'h5002, 1'b0, 2'd0, 1'b0);
    apply_word(32'h5003, 1'b1, 2'd3, 1'b0);
    drain("drain_full_pop");

    // Reset asserted mid-packet, then a fresh packet.
    do_reset();
    ready = 1'b1;
    apply_packet(8);
    wait_valid("rst_mid_valid");
    tick(); tick();
    n_rst = 1'b0;
    #1;
    check_output("rst_mid_valid", valid, 0);
    check_output("rst_mid_tx_pkts", tx_pkts, 0);
    check_output("rst_mid_full", full, 0);
    tick(); tick();
    n_rst = 1'b1;
    tick();
    apply_packet(2);
    drain("drain_after_rst");
    check_output("after_rst_tx_pkts", tx_pkts, 1);

    // Randomized packets under random backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 25; p++) begin
      apply_packet($urandom_range(1, DEPTH));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain("drain_random");
    rand_ready = 1'b0;
    ready = 1'b1;
    tick();
    check_output("final_queue_empty", exp_q.size(), 0);
    check_output("final_tx_pkts", tx_pkts, 26);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
